// File: rtl/cpu_run_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : run_mon_pkg
//  Description : Shared parameter defaults, FSM state encoding and helpers
//                for the CPU run monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package run_mon_pkg;

    localparam int DEF_PC_W        = 8;
    localparam int DEF_RST_CYCLES  = 4;
    localparam int DEF_MAX_CYCLES  = 650;
    localparam int DEF_TRACE_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } run_state_t;

    // The core is held in reset whenever no program is actually executing.
    function automatic logic holds_core_reset(input run_state_t s);
        return (s == ST_IDLE) || (s == ST_RST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_run_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_monitor_if
//  Description : Control/status bundle between a test controller (master)
//                and the CPU run monitor (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_run_monitor_if
    import run_mon_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int TRACE_DEPTH = DEF_TRACE_DEPTH
) ();

    localparam int CCW = $clog2(MAX_CYCLES + 1);
    localparam int TAW = $clog2(TRACE_DEPTH);

    logic            start;
    logic            abort;
    logic [PC_W-1:0] halt_pc;
    logic [PC_W-1:0] pc;
    logic            core_reset;
    logic            busy;
    logic            done;
    logic            halted;
    logic            timeout;
    logic [CCW-1:0]  cycle_count;
    logic [TAW-1:0]  trace_rd_idx;
    logic [PC_W-1:0] trace_rd_data;
    logic [TAW:0]    trace_count;

    modport master (
        output start, abort, halt_pc, pc, trace_rd_idx,
        input  core_reset, busy, done, halted, timeout, cycle_count,
               trace_rd_data, trace_count
    );

    modport slave (
        input  start, abort, halt_pc, pc, trace_rd_idx,
        output core_reset, busy, done, halted, timeout, cycle_count,
               trace_rd_data, trace_count
    );

endinterface
`default_nettype wire

// File: rtl/cpu_run_monitor_trace.sv
`default_nettype none
// ============================================================================
//  Module      : run_mon_trace
//  Description : Circular PC trace buffer. Records a PC on the first sample
//                after a clear and whenever the PC changes; oldest entry is
//                overwritten when full. Registered read port indexed by age.
//  Revision    : 1.0 - initial release
// ============================================================================
module run_mon_trace
    import run_mon_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int TRACE_DEPTH = DEF_TRACE_DEPTH
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic                           i_clr,
    input  wire logic                           i_sample,
    input  wire logic [PC_W-1:0]                i_pc,
    input  wire logic [$clog2(TRACE_DEPTH)-1:0] i_rd_idx,
    output logic      [PC_W-1:0]                o_rd_data,
    output logic      [$clog2(TRACE_DEPTH):0]   o_count
);

    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_FULL = CW'(TRACE_DEPTH);

    logic [PC_W-1:0] r_mem [TRACE_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [CW-1:0]   r_count;
    logic [PC_W-1:0] r_last;
    logic [PC_W-1:0] r_rd_data;

    logic            w_wr;
    logic [AW-1:0]   w_oldest;
    logic [AW-1:0]   w_rd_addr;
    logic            w_idx_valid;

    // An empty buffer means this is the first sample of the run.
    assign w_wr        = i_sample && ((r_count == '0) || (i_pc != r_last));
    // When full, the low bits of the count wrap to 0 so oldest == wptr.
    assign w_oldest    = r_wptr - r_count[AW-1:0];
    assign w_rd_addr   = w_oldest + i_rd_idx;
    assign w_idx_valid = ({1'b0, i_rd_idx} < r_count);

    // Write pointer, saturating fill count and last recorded PC.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wptr  <= '0;
            r_count <= '0;
            r_last  <= '0;
        end else if (w_wr) begin
            r_wptr <= r_wptr + AW'(1);
            r_last <= i_pc;
            if (r_count != c_FULL) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    // Trace storage; no reset needed since unfilled slots are never read out.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_pc;
        end
    end

    // Registered read by age; out-of-range ages read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_idx_valid ? r_mem[w_rd_addr] : '0;
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/cpu_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_monitor
//  Description : Sequences a CPU core through reset and run phases, detects
//                halt (PC match) or cycle-limit timeout, and optionally keeps
//                a trace of PC changes.
//                Optional feature macro: RUN_MON_TRACE_EN (PC trace buffer).
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_monitor
    import run_mon_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int TRACE_DEPTH = DEF_TRACE_DEPTH
) (
    input  wire logic         clk,
    input  wire logic         reset,
    cpu_run_monitor_if.slave  bus
);

    localparam int CCW = $clog2(MAX_CYCLES + 1);
    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam logic [RCW-1:0] c_RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [CCW-1:0] c_CYC_LAST = CCW'(MAX_CYCLES - 1);

    run_state_t     r_state;
    run_state_t     w_state_nxt;
    logic [RCW-1:0] r_rst_cnt;
    logic [CCW-1:0] r_cycle_count;
    logic           r_core_reset;
    logic           r_busy;
    logic           r_done;
    logic           r_halted;
    logic           r_timeout;

    logic           w_halt_hit;
    logic           w_time_hit;
    logic           w_enter_rst;
    logic           w_run_active;

    // Next-state decode; abort overrides everything, including start.
    always_comb begin
        w_state_nxt = r_state;
        w_halt_hit  = 1'b0;
        w_time_hit  = 1'b0;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.start) w_state_nxt = ST_RST;
                ST_RST:  if (r_rst_cnt == c_RST_LAST) w_state_nxt = ST_RUN;
                ST_RUN: begin
                    // A halt match in the final allowed cycle beats the timeout.
                    if (bus.pc == bus.halt_pc) begin
                        w_halt_hit  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else if (r_cycle_count == c_CYC_LAST) begin
                        w_time_hit  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: if (bus.start) w_state_nxt = ST_RST;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_enter_rst  = (w_state_nxt == ST_RST) && (r_state != ST_RST);
    assign w_run_active = (r_state == ST_RUN) && !bus.abort;

    // State register plus registered status derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_rst_cnt     <= '0;
            r_cycle_count <= '0;
            r_core_reset  <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_halted      <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_core_reset <= holds_core_reset(w_state_nxt);
            r_busy       <= (w_state_nxt == ST_RST) || (w_state_nxt == ST_RUN);
            r_done       <= (w_state_nxt == ST_DONE);
            if (w_enter_rst) begin
                r_rst_cnt     <= '0;
                r_cycle_count <= '0;
                r_halted      <= 1'b0;
                r_timeout     <= 1'b0;
            end else begin
                if (r_state == ST_RST) begin
                    r_rst_cnt <= r_rst_cnt + RCW'(1);
                end
                if (w_run_active) begin
                    r_cycle_count <= r_cycle_count + CCW'(1);
                    if (w_halt_hit) r_halted  <= 1'b1;
                    if (w_time_hit) r_timeout <= 1'b1;
                end
            end
        end
    end

    assign bus.core_reset  = r_core_reset;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.halted      = r_halted;
    assign bus.timeout     = r_timeout;
    assign bus.cycle_count = r_cycle_count;

`ifdef RUN_MON_TRACE_EN
    run_mon_trace #(
        .PC_W        (PC_W),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk       (clk),
        .rst       (reset),
        .i_clr     (w_enter_rst),
        .i_sample  (w_run_active),
        .i_pc      (bus.pc),
        .i_rd_idx  (bus.trace_rd_idx),
        .o_rd_data (bus.trace_rd_data),
        .o_count   (bus.trace_count)
    );
`else
    logic w_unused_trace_idx;
    assign w_unused_trace_idx = ^bus.trace_rd_idx;
    assign bus.trace_rd_data  = '0;
    assign bus.trace_count    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_run_monitor
//  Description : Self-checking bench for cpu_run_monitor: vector table for a
//                basic halt run, then directed timeout, trace, abort and
//                reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_monitor;

`ifdef RUN_MON_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;
    int   n;

    always #5 clk = ~clk;

    cpu_run_monitor_if #(.PC_W(8), .MAX_CYCLES(650), .TRACE_DEPTH(16)) bus ();

    cpu_run_monitor #(
        .PC_W(8), .RST_CYCLES(4), .MAX_CYCLES(650), .TRACE_DEPTH(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       st;
        logic       ab;
        logic [7:0] pc;
        logic       cr, bz, dn, hl, to;
        int         cc;
    } vec_t;

    vec_t v [13];

    function automatic vec_t mk(input logic st, input logic ab, input logic [7:0] pc,
                                input logic cr, input logic bz, input logic dn,
                                input logic hl, input logic to, input int cc);
        vec_t r;
        r.st = st; r.ab = ab; r.pc = pc;
        r.cr = cr; r.bz = bz; r.dn = dn; r.hl = hl; r.to = to; r.cc = cc;
        return r;
    endfunction

    function automatic int tr(input int x);
        return TR ? x : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag, input logic cr, input logic bz,
                          input logic dn, input logic hl, input logic to, input int cc);
        chk({tag, " core_reset"},  bus.core_reset,  cr);
        chk({tag, " busy"},        bus.busy,        bz);
        chk({tag, " done"},        bus.done,        dn);
        chk({tag, " halted"},      bus.halted,      hl);
        chk({tag, " timeout"},     bus.timeout,     to);
        chk({tag, " cycle_count"}, bus.cycle_count, cc);
    endtask

    // start pulse, then the four reset-phase cycles; leaves the DUT in RUN
    task automatic begin_run(input string tag);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        status({tag, " rst entry"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        repeat (4) tick();
        chk({tag, " run core_reset"}, bus.core_reset, 1'b0);
        chk({tag, " run busy"},       bus.busy,       1'b1);
    endtask

    task automatic trace_read(input string tag, input logic [3:0] idx, input int exp);
        bus.trace_rd_idx = idx;
        tick();
        chk(tag, bus.trace_rd_data, tr(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.pc = 8'h00; bus.halt_pc = 8'h05; bus.trace_rd_idx = 4'd0;

        // reset state
        repeat (3) tick();
        status("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("reset trace_count", bus.trace_count, 0);
        reset = 1'b0;
        tick();

        // basic run, halt at pc 05
        v[0]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        v[1]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        v[2]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        v[3]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        v[4]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        v[5]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        v[6]  = mk(1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        v[7]  = mk(1'b0, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        v[8]  = mk(1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        v[9]  = mk(1'b0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5);
        v[10] = mk(1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6);
        v[11] = mk(1'b0, 1'b0, 8'h06, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6);
        v[12] = mk(1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6);
        for (int i = 0; i < 13; i++) begin
            bus.start = v[i].st;
            bus.abort = v[i].ab;
            bus.pc    = v[i].pc;
            tick();
            status($sformatf("vec%0d", i), v[i].cr, v[i].bz, v[i].dn, v[i].hl, v[i].to, v[i].cc);
        end
        chk("basic trace_count", bus.trace_count, tr(6));
        trace_read("basic trace idx0", 4'd0, 0);
        trace_read("basic trace idx5", 4'd5, 5);
        trace_read("basic trace idx6", 4'd6, 0);

        // timeout: halt_pc never seen; a start mid-run must be ignored
        bus.halt_pc = 8'hFF;
        begin_run("tmo");
        n = 0;
        while (!bus.done && n < 700) begin
            bus.pc    = 8'(n % 200);
            bus.start = (n == 100);
            tick();
            n++;
        end
        bus.start = 1'b0;
        chk("tmo run cycles", n, 650);
        status("tmo end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 650);
        tick();
        chk("tmo frozen cycle_count", bus.cycle_count, 650);

        // halt match in the final allowed cycle beats timeout
        bus.halt_pc = 8'h31;
        begin_run("tie");
        n = 0;
        while (!bus.done && n < 700) begin
            bus.pc = (n == 649) ? 8'h31 : 8'h00;
            tick();
            n++;
        end
        chk("tie run cycles", n, 650);
        status("tie end", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 650);
        chk("tie trace_count", bus.trace_count, tr(2));

        // stuck pc: only changes are recorded
        bus.halt_pc = 8'hFF;
        begin_run("stuck");
        bus.pc = 8'h03;
        repeat (20) tick();
        bus.pc = 8'h04;
        repeat (3) tick();
        chk("stuck trace_count", bus.trace_count, tr(2));
        trace_read("stuck trace idx0", 4'd0, 8'h03);
        trace_read("stuck trace idx1", 4'd1, 8'h04);
        trace_read("stuck trace idx2", 4'd2, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("stuck abort core_reset", bus.core_reset, 1'b1);
        chk("stuck abort busy",       bus.busy,       1'b0);

        // 20 distinct PCs wrap the 16-entry trace
        bus.halt_pc = 8'h13;
        begin_run("wrap");
        for (int i = 0; i < 20; i++) begin
            bus.pc = 8'(i);
            tick();
        end
        status("wrap end", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 20);
        chk("wrap trace_count", bus.trace_count, tr(16));
        trace_read("wrap trace idx0",  4'd0,  8'h04);
        trace_read("wrap trace idx5",  4'd5,  8'h09);
        trace_read("wrap trace idx15", 4'd15, 8'h13);

        // abort at RUN cycle 10, then a clean rerun
        bus.halt_pc = 8'hFF;
        begin_run("abort");
        for (int i = 0; i < 9; i++) begin
            bus.pc = 8'(i);
            tick();
        end
        bus.pc = 8'h09;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort core_reset", bus.core_reset, 1'b1);
        chk("abort busy",       bus.busy,       1'b0);
        chk("abort done",       bus.done,       1'b0);
        tick();
        chk("abort idle busy",  bus.busy,       1'b0);
        bus.halt_pc = 8'h02;
        begin_run("rerun");
        for (int i = 0; i < 3; i++) begin
            bus.pc = 8'(i);
            tick();
        end
        status("rerun end", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        chk("rerun trace_count", bus.trace_count, tr(3));

        // start and abort together in DONE: abort wins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("startabort busy",       bus.busy,       1'b0);
        chk("startabort done",       bus.done,       1'b0);
        chk("startabort core_reset", bus.core_reset, 1'b1);

        // reset in the middle of a run
        bus.halt_pc = 8'hFF;
        begin_run("midrst");
        for (int i = 0; i < 3; i++) begin
            bus.pc = 8'(i);
            tick();
        end
        reset = 1'b1;
        tick();
        status("midrst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("midrst trace_count",   bus.trace_count,   0);
        chk("midrst trace_rd_data", bus.trace_rd_data, 0);
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
